tt_um_hoene_frame_sequencer: RTL
================================

// Module: tt_um_hoene_frame_sequencer
// PURPOSE
//  Sequences the decoded serial LED bitstream for tt_um_hoene_protocol_select.
//  Finds word alignment by detecting idle gaps, then generates sync, bit_counter
//  and a word index. Shifts in each 32-bit word, flags frame end and truncated
//  words, and drops sync when the selector reports a parity/protocol error.
//  Sits between the Manchester decoder (bit strobes) and the protocol selector.
// PARAMETERS
//  GAP_CYCLES  64   idle clk cycles without bit_valid that mark a frame/word gap
//  GAP_W       7    gap counter width; must hold GAP_CYCLES (>= clog2(GAP_CYCLES+1))
//  MAX_WORDS   255  word_index saturation value (8-bit index)
// PORTS
//  clk          in   1   global clock
//  rst          in   1   asynchronous, active-high reset
//  bit_valid    in   1   one-cycle strobe: bit_data holds a decoded bit
//  bit_data     in   1   decoded bit value, sampled only when bit_valid=1
//  error_in     in   1   error flag from protocol selector (level)
//  sync         out  1   alignment valid; drives selector in_sync
//  bit_counter  out  5   index (0..31) of the next bit to be accepted
//  word_index   out  8   number of complete words accepted in this frame
//  word_data    out  32  last complete word, MSB = bit 0 received
//  word_valid   out  1   one-cycle pulse: word_data updated
//  frame_end    out  1   one-cycle pulse: gap after >=1 complete word
//  word_abort   out  1   one-cycle pulse: gap hit with bit_counter != 0
// BEHAVIOUR
//  Reset (async): state=HUNT, sync=0, bit_counter=0, word_index=0, word_data=0,
//   all pulses 0, gap counter=0. Reset mid-word discards the partial word.
//  Gap counter: cleared on any bit_valid, else +1 per clk, saturates at
//   GAP_CYCLES. gap_hit = counter == GAP_CYCLES-1 && !bit_valid (one-cycle event).
//  States (registered, 2-bit):
//   HUNT  : sync=0; bits ignored; gap_hit -> SYNC (bit_counter=0, word_index=0).
//   SYNC  : sync=1. On bit_valid: shift bit_data into shift reg; bit_counter+1.
//           At bit 31: word_data<=shift|bit, word_valid=1 next cycle,
//           bit_counter wraps to 0, word_index+1 (saturating at MAX_WORDS).
//           gap_hit at bit_counter==0, word_index>0: frame_end=1, word_index=0.
//           gap_hit at bit_counter==0, word_index==0: no pulse, stay SYNC.
//           gap_hit at bit_counter!=0: word_abort=1, bit_counter=0,
//           word_index=0, shift reg cleared, stay SYNC.
//           error_in=1 -> ERROR.
//   ERROR : sync=0 (clears the selector error), bit_counter=0, word_index=0;
//           -> HUNT next cycle; realignment needs a full new gap.
//  Priority, same cycle: rst > error_in > bit_valid > gap_hit. error_in with
//   bit_valid drops the bit. bit_valid suppresses gap_hit by definition.
//  Latency: bit_counter/sync update 1 clk after bit_valid; word_valid is
//   asserted 1 clk after the bit-31 strobe. Outputs are all registered.
//  bit_valid strobes may be back-to-back (every cycle); no stall or backpressure.
//  word_index saturation: word 256+ still produces word_valid; the index holds 255.
// STRUCTURE
//  Shared include tt_um_hoene_led_defs.vh: WORD_BITS=32, BIT_CNT_W=5,
//   state encodings HUNT=0, SYNC=1, ERROR=2 (3 unused -> HUNT).
//  One sub-module: tt_um_hoene_gap_timer (GAP_CYCLES, GAP_W; in: clk, rst,
//   bit_valid; out: gap_hit). Shift register, counters and FSM stay top-level.
// TESTING
//  1 Reset, then 70 idle cycles -> sync=1 at cycle 64 after reset release,
//    bit_counter=0, no pulses.
//  2 Synced; send 32 bits 0xA5A5_0F0F (1 strobe / 4 clk) -> word_valid once,
//    word_data=0xA5A50F0F, word_index=1, bit_counter=0.
//  3 Two words, then 64 idle cycles -> frame_end pulse exactly once,
//    word_index 2 -> 0, sync stays 1.
//  4 10 bits, then gap -> word_abort=1, no word_valid, bit_counter 10 -> 0;
//    next 32 bits give a clean word.
//  5 error_in=1 with bit_valid in the same cycle -> bit dropped, sync=0 next
//    clk, HUNT; sync returns only after 64 idle cycles.
//  6 Assert rst at bit 17 -> all outputs 0 immediately (async); after release
//    needs a gap before sync; 300 words -> word_index holds at 255.

Source files
------------

// File: rtl/tt_um_hoene_frame_sequencer_pkg.sv
// Shared word geometry and sequencer state encoding for the LED frame sequencer.
package tt_um_hoene_frame_sequencer_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned IDX_W     = 8;

    typedef enum logic [1:0] {
        StHunt  = 2'd0,
        StSync  = 2'd1,
        StError = 2'd2
    } seq_state_e;

endpackage

// File: rtl/tt_um_hoene_gap_timer.sv
// Idle-gap detector: counts clocks since the last bit strobe and flags the
// single cycle on which the idle run reaches GAP_CYCLES.
module tt_um_hoene_gap_timer #(
    parameter int unsigned GAP_CYCLES = 64,
    parameter int unsigned GAP_W      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    output logic gap_hit
);

    localparam logic [GAP_W-1:0] GapMax  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GapLast = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (bit_valid) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GapMax) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Saturation above GapLast keeps this a one-shot per idle run.
    assign gap_hit = (gap_cnt_q == GapLast) && !bit_valid;

endmodule

// File: rtl/tt_um_hoene_frame_sequencer.sv
// Word aligner for the decoded LED bitstream: hunts for an idle gap, then
// assembles 32-bit words, counts them per frame and flags frame end / aborts.
module tt_um_hoene_frame_sequencer
    import tt_um_hoene_frame_sequencer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 64,
    parameter int unsigned GAP_W      = 7,
    parameter int unsigned MAX_WORDS  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    input  logic                 error_in,
    output logic                 sync,
    output logic [BIT_CNT_W-1:0] bit_counter,
    output logic [IDX_W-1:0]     word_index,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    output logic                 frame_end,
    output logic                 word_abort
);

    localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0]     MaxIdx  = IDX_W'(MAX_WORDS);

    seq_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_counter_q, bit_counter_d;
    logic [IDX_W-1:0]     word_index_q, word_index_d;
    logic [WORD_BITS-2:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] word_data_q, word_data_d;
    logic                 word_valid_q, word_valid_d;
    logic                 frame_end_q, frame_end_d;
    logic                 word_abort_q, word_abort_d;
    logic                 gap_hit;

    tt_um_hoene_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES),
        .GAP_W      (GAP_W)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .gap_hit   (gap_hit)
    );

    always_comb begin
        state_d       = state_q;
        bit_counter_d = bit_counter_q;
        word_index_d  = word_index_q;
        shift_d       = shift_q;
        word_data_d   = word_data_q;
        word_valid_d  = 1'b0;
        frame_end_d   = 1'b0;
        word_abort_d  = 1'b0;

        case (state_q)
            StHunt: begin
                if (gap_hit) begin
                    state_d       = StSync;
                    bit_counter_d = '0;
                    word_index_d  = '0;
                    shift_d       = '0;
                end
            end
            StSync: begin
                if (error_in) begin
                    state_d       = StError;
                    bit_counter_d = '0;
                    word_index_d  = '0;
                    shift_d       = '0;
                end else if (bit_valid) begin
                    if (bit_counter_q == LastBit) begin
                        word_data_d   = {shift_q, bit_data};
                        word_valid_d  = 1'b1;
                        bit_counter_d = '0;
                        shift_d       = '0;
                        if (word_index_q < MaxIdx) begin
                            word_index_d = word_index_q + IDX_W'(1);
                        end
                    end else begin
                        shift_d       = {shift_q[WORD_BITS-3:0], bit_data};
                        bit_counter_d = bit_counter_q + BIT_CNT_W'(1);
                    end
                end else if (gap_hit) begin
                    // A partial word is an abort; an empty gap after words closes the frame.
                    if (bit_counter_q != '0) begin
                        word_abort_d = 1'b1;
                    end else if (word_index_q != '0) begin
                        frame_end_d = 1'b1;
                    end
                    bit_counter_d = '0;
                    word_index_d  = '0;
                    shift_d       = '0;
                end
            end
            StError: begin
                state_d       = StHunt;
                bit_counter_d = '0;
                word_index_d  = '0;
                shift_d       = '0;
            end
            default: begin
                state_d       = StHunt;
                bit_counter_d = '0;
                word_index_d  = '0;
                shift_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            bit_counter_q <= '0;
            word_index_q  <= '0;
            shift_q       <= '0;
            word_data_q   <= '0;
            word_valid_q  <= 1'b0;
            frame_end_q   <= 1'b0;
            word_abort_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_counter_q <= bit_counter_d;
            word_index_q  <= word_index_d;
            shift_q       <= shift_d;
            word_data_q   <= word_data_d;
            word_valid_q  <= word_valid_d;
            frame_end_q   <= frame_end_d;
            word_abort_q  <= word_abort_d;
        end
    end

    assign sync        = (state_q == StSync);
    assign bit_counter = bit_counter_q;
    assign word_index  = word_index_q;
    assign word_data   = word_data_q;
    assign word_valid  = word_valid_q;
    assign frame_end   = frame_end_q;
    assign word_abort  = word_abort_q;

endmodule
